// File: rtl/debouncer.sv
// rtl/debouncer.sv - switch debouncer with two-flop synchronizer and stable-time counter
//
// Parameters:
//   ClkFreq    - clock frequency in Hz
//   StableTime - time in ms the synchronized input must stay constant
// Ports:
//   clk_i      - rising-edge clock
//   rst_i      - asynchronous active-high reset
//   sw_i       - raw, asynchronous, bouncing switch level
//   db_level_o - registered debounced level
//   db_tick_o  - registered one-cycle pulse on each debounced 0->1 transition

module debouncer #(
    parameter int ClkFreq    = 100_000_000,
    parameter int StableTime = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_level_o,
    output logic db_tick_o
);

    // Widened product so large clock rates do not overflow 32-bit arithmetic.
    localparam longint NLong = longint'(ClkFreq) * longint'(StableTime) / 1000;
    localparam int     N     = int'(NLong);
    localparam int     CW    = $clog2(N) + 1;
    localparam logic [CW-1:0] CntMax = CW'(N - 1);

    generate
        if (N < 2) begin : g_bad_n
            $error("debouncer: ClkFreq*StableTime/1000 must be at least 2");
        end
    endgenerate

    // ff1/ff2 synchronize sw_i; ff3 keeps the previous synchronized sample.
    logic          ff1;
    logic          ff2;
    logic          ff3;
    logic [CW-1:0] count;

    logic          change;
    logic          at_max;
    logic [CW-1:0] count_next;
    logic          level_next;
    logic          tick_next;

    always_comb begin
        change     = (ff2 != ff3);
        at_max     = (count == CntMax);
        count_next = count;
        level_next = db_level_o;
        tick_next  = 1'b0;

        if (change) begin
            count_next = '0;
        end else if (!at_max) begin
            count_next = count + 1'b1;
        end

        // Commit only after the sample has been unchanged for the full window;
        // the counter saturates so a long-stable input keeps qualifying.
        if (!change && at_max && (ff3 != db_level_o)) begin
            level_next = ff3;
            tick_next  = ff3;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff1        <= 1'b0;
            ff2        <= 1'b0;
            ff3        <= 1'b0;
            count      <= '0;
            db_level_o <= 1'b0;
            db_tick_o  <= 1'b0;
        end else begin
            ff1        <= sw_i;
            ff2        <= ff1;
            ff3        <= ff2;
            count      <= count_next;
            db_level_o <= level_next;
            db_tick_o  <= tick_next;
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - randomized self-checking bench for debouncer against a sliding-window model

module tb_debouncer;

    localparam int N = 10;

    logic clk = 1'b0;
    logic rst;
    logic sw;
    logic db_level;
    logic db_tick;

    always #5 clk = ~clk;

    debouncer #(
        .ClkFreq   (1000),
        .StableTime(10)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sw_i      (sw),
        .db_level_o(db_level),
        .db_tick_o (db_tick)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: history of values sampled by the design at each edge.
    logic cap[$];
    logic exp_lvl;
    logic exp_tick;
    int   edge_no     = 0;
    int   last_change = 0;
    int   rise_edge   = -1;
    int   fall_edge   = -1;
    int   ticks       = 0;
    logic prev_lvl    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cap.delete();
        for (int i = 0; i < N + 3; i++) cap.push_back(1'b0);
        exp_lvl  = 1'b0;
        exp_tick = 1'b0;
        prev_lvl = 1'b0;
    endtask

    // Level follows the value sampled two edges earlier once that value has
    // been sampled identically over N+1 consecutive edges.
    task automatic step(input logic v, input string tag);
        int   last;
        logic same;
        sw = v;
        @(posedge clk);
        edge_no++;
        if (v != cap[cap.size() - 1]) last_change = edge_no;
        cap.push_back(v);
        void'(cap.pop_front());
        last = cap.size() - 1;
        same = 1'b1;
        for (int i = last - 2 - N; i < last - 2; i++)
            if (cap[i] != cap[last - 2]) same = 1'b0;
        exp_tick = 1'b0;
        if (same && (cap[last - 2] != exp_lvl)) begin
            exp_tick = cap[last - 2];
            exp_lvl  = cap[last - 2];
        end
        #1;
        check({tag, "_lvl"}, 32'(db_level), 32'(exp_lvl));
        check({tag, "_tick"}, 32'(db_tick), 32'(exp_tick));
        if (db_level === 1'b1 && prev_lvl === 1'b0) rise_edge = edge_no;
        if (db_level === 1'b0 && prev_lvl === 1'b1) fall_edge = edge_no;
        if (db_tick === 1'b1) ticks++;
        prev_lvl = db_level;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ff1"}, 32'(dut.ff1), 0);
        check({tag, "_ff2"}, 32'(dut.ff2), 0);
        check({tag, "_ff3"}, 32'(dut.ff3), 0);
        check({tag, "_cnt"}, 32'(dut.count), 0);
        check({tag, "_lvl"}, 32'(db_level), 0);
        check({tag, "_tick"}, 32'(db_tick), 0);
    endtask

    // Assert reset between clock edges, confirm it acts without an edge,
    // hold it across one edge, then release away from the edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero({tag, "_async"});
        @(posedge clk);
        #1;
        check_all_zero({tag, "_held"});
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int   n;
        int   len;
        logic b;

        rst = 1'b1;
        sw  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2;
        rst = 1'b0;

        // Quiet input after reset: no activity.
        ticks = 0;
        repeat (50) step(1'b0, "quiet");
        check("quiet_ticks", 32'(ticks), 0);

        // Clean rising step.
        ticks = 0; rise_edge = -1;
        repeat (25) step(1'b1, "rise");
        check("rise_latency", 32'(rise_edge - last_change), 12);
        check("rise_ticks", 32'(ticks), 1);

        // Short low glitch while high.
        ticks = 0; fall_edge = -1;
        repeat (5) step(1'b0, "glitch");
        repeat (20) step(1'b1, "glitch");
        check("glitch_ticks", 32'(ticks), 0);
        check("glitch_nofall", 32'(fall_edge), 32'(-1));

        // Falling step: level drops, never ticks.
        ticks = 0; fall_edge = -1;
        repeat (25) step(1'b0, "fall");
        check("fall_latency", 32'(fall_edge - last_change), 12);
        check("fall_ticks", 32'(ticks), 0);

        // Bounce with 1..5-cycle runs, then settle high.
        ticks = 0; rise_edge = -1;
        n = 0;
        b = 1'b1;
        while (n < 40) begin
            len = int'($urandom_range(1, 5));
            repeat (len) step(b, "bounce");
            n += len;
            b = ~b;
        end
        repeat (25) step(1'b1, "bounce");
        check("bounce_latency", 32'(rise_edge - last_change), 12);
        check("bounce_ticks", 32'(ticks), 1);

        // Reset in the middle of a rising count.
        repeat (25) step(1'b0, "pre_rst");
        repeat (9) step(1'b1, "mid_rst");
        check("mid_rst_count", 32'(dut.count), 6);
        async_reset("mid_rst");
        ticks = 0; rise_edge = -1;
        repeat (25) step(1'b1, "post_rst");
        check("post_rst_latency", 32'(rise_edge - last_change), 12);
        check("post_rst_ticks", 32'(ticks), 1);

        // Random run lengths around the stable window, with occasional resets.
        for (int r = 0; r < 60; r++) begin
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 16));
            repeat (len) step(b, "rand");
            if ($urandom_range(0, 14) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
